// File: rtl/fir_pkg.sv
// Constants shared by the FIR datapath blocks (myfir, signal_gen, data_sink, fir_out_buffer).
package fir_pkg;
    localparam int NB        = 10;
    localparam int DEPTH_DEF = 8;
    localparam int DROPS_W   = 8;
endpackage

// File: rtl/fir_buf_mem.sv
// DEPTH x NB register file: one synchronous write port, one asynchronous read port.
module fir_buf_mem import fir_pkg::*; #(
    parameter int DEPTH = fir_pkg::DEPTH_DEF,
    parameter int W     = fir_pkg::NB,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fir_out_buffer.sv
// Elastic FIFO stage after myfir: absorbs un-throttled FIR samples and re-presents
// them under valid/ready, counting any sample lost to overflow.
module fir_out_buffer import fir_pkg::*; #(
    parameter int NB    = fir_pkg::NB,
    parameter int DEPTH = fir_pkg::DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NB-1:0]      DIN,
    input  logic               VIN,
    input  logic               RDY,
    output logic [NB-1:0]      DOUT,
    output logic               VOUT,
    output logic               FULL,
    output logic [AW:0]        COUNT,
    output logic               OVF,
    input  logic               CLR_OVF,
    output logic [DROPS_W-1:0] DROPS
);

    localparam logic [AW:0]        DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [DROPS_W-1:0] DROPS_MAX = '1;

    logic [AW-1:0] wptr, rptr, rptr_n;
    logic [AW:0]   count_n;
    logic          push, pop, drop;
    logic [NB-1:0] mem_rdata;

    assign pop    = (COUNT != '0) && RDY;
    assign push   = VIN && ((COUNT != DEPTH_C) || pop);
    assign drop   = VIN && (COUNT == DEPTH_C) && !pop;
    assign rptr_n = pop ? rptr + 1'b1 : rptr;

    always_comb begin
        count_n = COUNT;
        if (push && !pop)      count_n = COUNT + 1'b1;
        else if (pop && !push) count_n = COUNT - 1'b1;
    end

    // Read port looks at the next head so DOUT can be registered.
    fir_buf_mem #(.DEPTH(DEPTH), .W(NB), .AW(AW)) u_mem (
        .CLK   (CLK),
        .we    (push),
        .waddr (wptr),
        .wdata (DIN),
        .raddr (rptr_n),
        .rdata (mem_rdata)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            wptr  <= '0;
            rptr  <= '0;
            COUNT <= '0;
            DOUT  <= '0;
            OVF   <= 1'b0;
            DROPS <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            rptr  <= rptr_n;
            COUNT <= count_n;
            // Next head being written this same cycle has not reached memory yet.
            if (count_n != '0)
                DOUT <= (push && (wptr == rptr_n)) ? DIN : mem_rdata;
            if (drop) begin
                OVF <= 1'b1;
                if (CLR_OVF)                DROPS <= DROPS_W'(1);
                else if (DROPS != DROPS_MAX) DROPS <= DROPS + 1'b1;
            end else if (CLR_OVF) begin
                OVF   <= 1'b0;
                DROPS <= '0;
            end
        end
    end

    assign VOUT = (COUNT != '0);
    assign FULL = (COUNT == DEPTH_C);

endmodule

// File: tb/tb_fir_out_buffer.sv
// Directed self-checking bench for fir_out_buffer (NB=10, DEPTH=8).
module tb_fir_out_buffer;
    import fir_pkg::*;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [NB-1:0] DIN = '0;
    logic          VIN = 1'b0;
    logic          RDY = 1'b0;
    logic          CLR_OVF = 1'b0;
    logic [NB-1:0] DOUT;
    logic          VOUT, FULL, OVF;
    logic [3:0]    COUNT;
    logic [7:0]    DROPS;

    int tests = 0;
    int fails = 0;
    int exp_v;
    int max_cnt;

    fir_out_buffer dut (
        .CLK(CLK), .RST(RST), .DIN(DIN), .VIN(VIN), .RDY(RDY),
        .DOUT(DOUT), .VOUT(VOUT), .FULL(FULL), .COUNT(COUNT),
        .OVF(OVF), .CLR_OVF(CLR_OVF), .DROPS(DROPS)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        if (obs != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic fill(input int base);
        RDY = 1'b0;
        VIN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            DIN = NB'(base + i);
            step();
        end
        VIN = 1'b0;
    endtask

    initial begin
        // reset
        step(); step();
        RST = 1'b1;
        check("rst_count", COUNT, 0);
        check("rst_vout", VOUT, 0);
        check("rst_full", FULL, 0);
        check("rst_ovf", OVF, 0);
        check("rst_drops", DROPS, 0);
        check("rst_dout", DOUT, 0);

        // single sample
        RDY = 1'b1; VIN = 1'b1; DIN = 10'h155;
        step();
        VIN = 1'b0;
        check("single_vout", VOUT, 1);
        check("single_dout", DOUT, 10'h155);
        step();
        check("single_count_after", COUNT, 0);
        check("single_vout_after", VOUT, 0);
        check("single_dout_hold", DOUT, 10'h155);

        // fill without drain, then overflow
        fill(1);
        check("fill_full", FULL, 1);
        check("fill_count", COUNT, 8);
        VIN = 1'b1; DIN = 10'd9;
        step();
        VIN = 1'b0;
        check("ovf_flag", OVF, 1);
        check("ovf_drops", DROPS, 1);
        check("ovf_count", COUNT, 8);
        RDY = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("drain_vout", VOUT, 1);
            check("drain_dout", DOUT, i);
            step();
        end
        check("drain_empty", VOUT, 0);
        CLR_OVF = 1'b1;
        step();
        CLR_OVF = 1'b0;
        check("clr1_ovf", OVF, 0);
        check("clr1_drops", DROPS, 0);

        // simultaneous push/pop while full
        fill(1);
        RDY = 1'b1;
        exp_v = 1;
        for (int c = 0; c < 14; c++) begin
            VIN = (c < 2);
            DIN = NB'(9 + c);
            if (VOUT) begin
                check("simul_dout", DOUT, exp_v);
                exp_v++;
            end
            step();
            if (c < 2) check("simul_count", COUNT, 8);
        end
        VIN = 1'b0;
        check("simul_total", exp_v, 11);
        check("simul_drops", DROPS, 0);
        check("simul_ovf", OVF, 0);

        // wrap-around streaming
        exp_v = 100;
        max_cnt = 0;
        for (int c = 0; c < 22; c++) begin
            VIN = (c < 20);
            DIN = NB'(100 + c);
            if (VOUT) begin
                check("wrap_dout", DOUT, exp_v);
                exp_v++;
            end
            step();
            if (int'(COUNT) > max_cnt) max_cnt = COUNT;
        end
        VIN = 1'b0;
        check("wrap_total", exp_v, 120);
        check("wrap_maxcount", max_cnt, 1);

        // saturation and clear
        fill(200);
        VIN = 1'b1;
        for (int i = 0; i < 300; i++) begin
            DIN = NB'(i);
            step();
        end
        VIN = 1'b0;
        check("sat_drops", DROPS, 255);
        check("sat_ovf", OVF, 1);
        check("sat_count", COUNT, 8);
        CLR_OVF = 1'b1;
        step();
        check("clr2_ovf", OVF, 0);
        check("clr2_drops", DROPS, 0);
        VIN = 1'b1;
        step();
        CLR_OVF = 1'b0; VIN = 1'b0;
        check("clr_drop_ovf", OVF, 1);
        check("clr_drop_drops", DROPS, 1);

        // reset mid-stream with COUNT=5
        RDY = 1'b1;
        step(); step(); step();
        RDY = 1'b0;
        check("mid_count", COUNT, 5);
        check("mid_dout", DOUT, 203);
        RST = 1'b0; VIN = 1'b1; DIN = 10'h3FF;
        step();
        RST = 1'b1; VIN = 1'b0;
        check("mrst_count", COUNT, 0);
        check("mrst_vout", VOUT, 0);
        check("mrst_dout", DOUT, 0);
        check("mrst_ovf", OVF, 0);
        check("mrst_drops", DROPS, 0);
        RDY = 1'b1; VIN = 1'b1; DIN = 10'h2AA;
        step();
        VIN = 1'b0;
        check("post_rst_vout", VOUT, 1);
        check("post_rst_dout", DOUT, 10'h2AA);
        step();
        check("post_rst_empty", COUNT, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
